// File: rtl/polmul_sequencer_if.sv
// Command/response bundle between a requester and polmul_sequencer, including
// the start pulses and bank select that drive the NTT address generator.
interface polmul_sequencer_if;
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the requester keeps cmd_valid and cmd_op stable until that edge.
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       start_fntt;
  logic       start_pwm2;
  logic       start_intt;
  logic [1:0] poly_sel;
  logic       busy;
  logic       done;
  logic [1:0] resp_op;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, start_fntt, start_pwm2, start_intt, poly_sel, busy, done, resp_op
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, start_fntt, start_pwm2, start_intt, poly_sel, busy, done, resp_op
  );
endinterface

// File: rtl/polmul_sequencer.sv
// Steps the NTT address generator through FNTT/PWM2/INTT operations for one command.
// Optional macro SEQ_PERF_EN adds perf_cycles (acceptance-to-done cycle count).
module polmul_sequencer #(
  parameter int FNTT_CYC = 225,
  parameter int PWM_CYC  = 160,
  parameter int INTT_CYC = 225,
  parameter int DRAIN    = 8
) (
  input  logic               clk,
  input  logic               reset,
  polmul_sequencer_if.slave  bus,
  output logic [1:0]         dbg_state
`ifdef SEQ_PERF_EN
  ,
  output logic [15:0]        perf_cycles
`endif
);

  localparam int MAX_A  = (FNTT_CYC > PWM_CYC) ? FNTT_CYC : PWM_CYC;
  localparam int MAX_OP = (MAX_A > INTT_CYC) ? MAX_A : INTT_CYC;
  localparam int CNT_WR = $clog2(MAX_OP + DRAIN + 1);
  localparam int CNT_W  = (CNT_WR < 1) ? 1 : CNT_WR;

  localparam logic [CNT_W-1:0] N_FNTT = CNT_W'(FNTT_CYC + DRAIN);
  localparam logic [CNT_W-1:0] N_PWM2 = CNT_W'(PWM_CYC + DRAIN);
  localparam logic [CNT_W-1:0] N_INTT = CNT_W'(INTT_CYC + DRAIN);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_FIN} state_t;
  typedef enum logic [1:0] {K_FNTT, K_PWM2, K_INTT} kind_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  kind_t      cur_kind;
  logic [1:0] cur_sel;
  logic       last_step;
  logic       accept;

  logic       cmd_ready;
  logic       start_fntt, start_pwm2, start_intt;
  logic [1:0] poly_sel;
  logic       busy, done;
  logic [1:0] resp_op;

  // Operation and operand bank for the step currently being issued or run.
  always_comb begin
    cur_kind  = K_FNTT;
    cur_sel   = 2'd0;
    last_step = 1'b1;
    case (op_q)
      2'd0: begin cur_kind = K_FNTT; cur_sel = 2'd0; end
      2'd1: begin cur_kind = K_PWM2; cur_sel = 2'd2; end
      2'd2: begin cur_kind = K_INTT; cur_sel = 2'd2; end
      default: begin
        last_step = (step_q == 2'd3);
        case (step_q)
          2'd0:    begin cur_kind = K_FNTT; cur_sel = 2'd0; end
          2'd1:    begin cur_kind = K_FNTT; cur_sel = 2'd1; end
          2'd2:    begin cur_kind = K_PWM2; cur_sel = 2'd2; end
          default: begin cur_kind = K_INTT; cur_sel = 2'd2; end
        endcase
      end
    endcase
  end

  assign accept = (state_q == S_IDLE) && bus.cmd_valid;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    start_fntt = 1'b0;
    start_pwm2 = 1'b0;
    start_intt = 1'b0;
    poly_sel   = 2'd0;
    busy       = 1'b0;
    done       = 1'b0;
    resp_op    = 2'd0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          step_d  = 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy     = 1'b1;
        poly_sel = cur_sel;
        case (cur_kind)
          K_FNTT:  begin start_fntt = 1'b1; cnt_d = N_FNTT; end
          K_PWM2:  begin start_pwm2 = 1'b1; cnt_d = N_PWM2; end
          default: begin start_intt = 1'b1; cnt_d = N_INTT; end
        endcase
        state_d = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        poly_sel = cur_sel;
        cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        // cnt_q == 1 marks the Nth and final run cycle of this step.
        if (cnt_q <= CNT_W'(1)) begin
          if (last_step) begin
            state_d = S_FIN;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        busy    = 1'b1;
        done    = 1'b1;
        resp_op = op_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      step_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.start_fntt = start_fntt;
  assign bus.start_pwm2 = start_pwm2;
  assign bus.start_intt = start_intt;
  assign bus.poly_sel   = poly_sel;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.resp_op    = resp_op;
  assign dbg_state      = state_q;

`ifdef SEQ_PERF_EN
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] perf_q, perf_d;

  // cyc_q equals k in cycle c+k; perf_q is loaded so the FIN cycle shows the total.
  always_comb begin
    cyc_d  = cyc_q;
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (accept) cyc_d = 16'd1;
    end else if (cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
    if ((state_q == S_RUN) && (state_d == S_FIN)) begin
      perf_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q  <= 16'd0;
      perf_q <= 16'd0;
    end else begin
      cyc_q  <= cyc_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_polmul_sequencer.sv
// Directed table-driven bench for polmul_sequencer (default and DRAIN=0 instances).
module tb_polmul_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  polmul_sequencer_if bus();
  polmul_sequencer_if bus0();
  logic [1:0] dbg_state, dbg_state0;
`ifdef SEQ_PERF_EN
  logic [15:0] perf_cycles, perf_cycles0;
`endif

  polmul_sequencer dut (
    .clk(clk), .reset(rst_n), .bus(bus), .dbg_state(dbg_state)
`ifdef SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  polmul_sequencer #(.DRAIN(0)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0), .dbg_state(dbg_state0)
`ifdef SEQ_PERF_EN
    , .perf_cycles(perf_cycles0)
`endif
  );

  // Start kinds as {fntt, pwm2, intt}
  localparam logic [2:0] FN = 3'b100;
  localparam logic [2:0] PW = 3'b010;
  localparam logic [2:0] IN = 3'b001;

  typedef struct packed {
    logic [1:0]       op;
    logic [2:0]       n;
    logic [3:0][9:0]  st;
    logic [3:0][2:0]  kd;
    logic [3:0][1:0]  sl;
    logic [9:0]       done_off;
  } vec_t;

  vec_t tbl[4];

  function automatic vec_t mk(input logic [1:0] op, input int n,
                              input int s0, input int s1, input int s2, input int s3,
                              input logic [2:0] k0, input logic [2:0] k1,
                              input logic [2:0] k2, input logic [2:0] k3,
                              input logic [1:0] l0, input logic [1:0] l1,
                              input logic [1:0] l2, input logic [1:0] l3,
                              input int d);
    vec_t v;
    v.op = op; v.n = 3'(n);
    v.st[0] = 10'(s0); v.st[1] = 10'(s1); v.st[2] = 10'(s2); v.st[3] = 10'(s3);
    v.kd[0] = k0; v.kd[1] = k1; v.kd[2] = k2; v.kd[3] = k3;
    v.sl[0] = l0; v.sl[1] = l1; v.sl[2] = l2; v.sl[3] = l3;
    v.done_off = 10'(d);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start pulses must never overlap on either instance.
  always @(negedge clk) begin
    if (rst_n && (bus.start_fntt | bus.start_pwm2 | bus.start_intt |
                  bus0.start_fntt | bus0.start_pwm2 | bus0.start_intt)) begin
      chk("start_onehot", 32'(($countones({bus.start_fntt, bus.start_pwm2, bus.start_intt}) > 1) ||
                              ($countones({bus0.start_fntt, bus0.start_pwm2, bus0.start_intt}) > 1)),
          32'd0);
    end
  end

  // Called at a negedge; returns the acceptance cycle in c.
  task automatic run_cmd(input vec_t v, input bit hold, output int c);
    bit acc = 1'b0;
    int t = 0;
    logic [9:0] obs, exp;
    int si;
    c = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    while (!acc && t < 20) begin
      if (bus.cmd_ready) begin
        acc = 1'b1;
        c = cyc;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    chk("accept", 32'(acc), 32'd1);
    if (!acc) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= int'(v.done_off) + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) bus.cmd_valid = 1'b0;
      si = -1;
      for (int i = 0; i < int'(v.n); i++) if (int'(v.st[i]) <= k) si = i;
      exp = '0;
      if (si >= 0 && k < int'(v.done_off)) begin
        exp[9:7] = (k == int'(v.st[si])) ? v.kd[si] : 3'b000;
        exp[6:5] = v.sl[si];
      end
      exp[4] = (k <= int'(v.done_off));
      exp[3] = (k == int'(v.done_off));
      exp[2:1] = (k == int'(v.done_off)) ? v.op : 2'd0;
      exp[0] = (k > int'(v.done_off));
      obs = {bus.start_fntt, bus.start_pwm2, bus.start_intt, bus.poly_sel,
             bus.busy, bus.done, bus.resp_op, bus.cmd_ready};
      chk($sformatf("op%0d_k%0d_outs", v.op, k), 32'(obs), 32'(exp));
`ifdef SEQ_PERF_EN
      if (k == int'(v.done_off)) chk($sformatf("op%0d_perf", v.op), 32'(perf_cycles), 32'(v.done_off));
`endif
    end
  endtask

  task automatic run_drain0;
    int c;
    int k = 0;
    bit seen = 1'b0;
    bus0.cmd_valid = 1'b1;
    bus0.cmd_op    = 2'd1;
    chk("d0_ready", 32'(bus0.cmd_ready), 32'd1);
    c = cyc;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    chk("d0_start_pwm2", 32'({bus0.start_fntt, bus0.start_pwm2, bus0.start_intt, bus0.poly_sel}),
        32'({PW, 2'd2}));
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      if (bus0.done) seen = 1'b1;
    end
    chk("d0_done_seen", 32'(seen), 32'd1);
    chk("d0_done_cycle", 32'(cyc - c), 32'd162);
    chk("d0_resp_op", 32'(bus0.resp_op), 32'd1);
  endtask

  int c_a, c_b, c_x;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus0.cmd_valid = 1'b0;
    bus0.cmd_op    = 2'd0;
    tbl[0] = mk(2'd0, 1, 1, 0, 0, 0, FN, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 235);
    tbl[1] = mk(2'd1, 1, 1, 0, 0, 0, PW, 3'd0, 3'd0, 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 170);
    tbl[2] = mk(2'd2, 1, 1, 0, 0, 0, IN, 3'd0, 3'd0, 3'd0, 2'd2, 2'd0, 2'd0, 2'd0, 235);
    tbl[3] = mk(2'd3, 4, 1, 235, 469, 638, FN, FN, PW, IN, 2'd0, 2'd1, 2'd2, 2'd2, 872);

    // Reset held low for three cycles.
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({bus.start_fntt, bus.start_pwm2, bus.start_intt, bus.poly_sel,
                         bus.busy, bus.done, bus.resp_op}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
`ifdef SEQ_PERF_EN
    chk("rst_perf", 32'(perf_cycles), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_outs", 32'({bus.start_fntt, bus.start_pwm2, bus.start_intt, bus.poly_sel,
                              bus.busy, bus.done, bus.resp_op}), 32'd0);

    run_drain0();

    for (int i = 0; i < 4; i++) run_cmd(tbl[i], 1'b0, c_x);

    // cmd_valid held across a PWM2 run: the next acceptance lands right after done.
    run_cmd(tbl[1], 1'b1, c_a);
    run_cmd(tbl[1], 1'b0, c_b);
    chk("hold_reaccept_cycle", 32'(c_b - c_a), 32'd171);

    // Abort an INTT run with reset at c+100.
    begin
      bit stray = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd2;
      chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (99) @(negedge clk);
      chk("abort_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_outs", 32'({bus.start_fntt, bus.start_pwm2, bus.start_intt, bus.poly_sel,
                             bus.busy, bus.done}), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (bus.done | bus.start_fntt | bus.start_pwm2 | bus.start_intt | bus.busy) stray = 1'b1;
      end
      chk("abort_silent", 32'(stray), 32'd0);
    end
    run_cmd(tbl[0], 1'b0, c_x);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/polmul_sequencer.md
POLMUL_SEQUENCER -- requirements
Module: polmul_sequencer

Interface
REQ-001 Parameter FNTT_CYC, default 225, forward-NTT active cycles per start pulse (5x32 + 1 stall + 2x32).
REQ-002 Parameter PWM_CYC, default 160, pointwise-multiply active cycles per start pulse (32 loops x 5).
REQ-003 Parameter INTT_CYC, default 225, inverse-NTT active cycles per start pulse (32 + 1 stall + 6x32).
REQ-004 Parameter DRAIN, default 8, extra cycles after each operation for write-back pipeline drain.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 cmd_valid  input  1  requester command valid.
REQ-008 cmd_op  input  2  0=FNTT, 1=PWM2, 2=INTT, 3=POLMUL (FNTT, FNTT, PWM2, INTT).
REQ-009 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-010 start_fntt, start_pwm2, start_intt  output  1 each  one-cycle start pulses to the address generator.
REQ-011 poly_sel  output  2  operand bank select for the active step: 0=A, 1=B, 2=product.
REQ-012 busy  output  1  high from the cycle after acceptance through the done cycle, inclusive.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 resp_op  output  2  opcode of the completed command, valid while done=1.

Function
REQ-015 States: IDLE, ISSUE, RUN, FIN; cmd_ready=1 only in IDLE.
REQ-016 IDLE->ISSUE on acceptance; cmd_op latched; step index cleared to 0.
REQ-017 ISSUE lasts 1 cycle: exactly one start_* high per the current step; counter loaded with N=OPCYC+DRAIN, where OPCYC is the parameter for that step's operation; ISSUE->RUN.
REQ-018 RUN decrements the counter every cycle for N cycles; on the last cycle go to ISSUE if further steps remain (step index +1), else go to FIN.
REQ-019 FIN lasts 1 cycle: done=1, resp_op=latched op; FIN->IDLE.
REQ-020 Steps for cmd_op 0/1/2: one step each (FNTT/PWM2/INTT), poly_sel=0/2/2.
REQ-021 Steps for cmd_op 3: FNTT poly_sel=0; FNTT poly_sel=1; PWM2 poly_sel=2; INTT poly_sel=2.
REQ-022 poly_sel stays stable from ISSUE through the end of that step's RUN; poly_sel=0 in IDLE and FIN.
REQ-023 Timing: acceptance in cycle c gives the first start pulse in c+1; each step occupies 1+N cycles; done fires in cycle c+1+sum(1+N_i).
REQ-024 cmd_valid outside IDLE is ignored; the requester holds it until accepted; no queuing.
REQ-025 In the FIN cycle cmd_ready=0; a new command is accepted no earlier than the following cycle.
REQ-026 The counter is wide enough for max(OPCYC)+DRAIN; no wrap occurs; start_* are never asserted together.

Reset
REQ-027 While reset=0 at a rising edge: state=IDLE, counter=0, step=0, start_*=0, poly_sel=0, busy=0, done=0, resp_op=0; cmd_ready=1 after release.
REQ-028 Reset mid-command aborts it silently: no done pulse and no further start pulses.

Configuration
REQ-029 Macro SEQ_PERF_EN defined: adds output perf_cycles[15:0], the cycle count from acceptance to done of the last completed command; it saturates at 0xFFFF, updates in the FIN cycle, and resets to 0.
REQ-030 Macro SEQ_PERF_EN undefined: perf_cycles port and its logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset low 3 cycles, then high -> all outputs 0, cmd_ready=1.
REQ-032 cmd_op=0 accepted in cycle c (defaults) -> start_fntt in c+1 only; done with resp_op=0 in c+235; busy high c+1..c+235.
REQ-033 cmd_op=3 accepted in c -> start_fntt at c+1 (sel 0) and c+235 (sel 1); start_pwm2 at c+469 (sel 2); start_intt at c+638; done at c+872; perf_cycles=872 with SEQ_PERF_EN.
REQ-034 cmd_valid held high through a cmd_op=1 run -> the second command is accepted only in the cycle after done; first done at c+170.
REQ-035 Reset asserted at c+100 of a cmd_op=2 run -> no done and no start pulse follow; the next command behaves normally.
REQ-036 DRAIN=0, cmd_op=1 -> done at c+162; no simultaneous start_* across all runs (assertion).
